uart_wb_host: RTL and testbench

UART_WB_HOST -- requirements
Module: uart_wb_host

---
 rtl/uart_wb_host.sv | 165 ++++++++++++++++
 tb/tb_uart_wb_host.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_host.sv
// UART Wishbone host: polls the UART CSR, drains RBR into an RX FIFO
// and forwards host bytes into THR.
module uart_wb_host #(
  parameter int RX_AW = 4,
  parameter int TMO   = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  output logic       wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  input  logic       wbm_ack_i,
  input  logic       en_i,
  input  logic [7:0] tx_dat_i,
  input  logic       tx_vld_i,
  output logic       tx_rdy_o,
  output logic [7:0] rx_dat_o,
  output logic       rx_vld_o,
  input  logic       rx_rdy_i,
  output logic [3:0] err_o,
  input  logic       err_clr_i
);
  localparam int DEPTH = 1 << RX_AW;
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_CSR,
    RD_RBR,
    WR_THR
  } state_t;

  state_t state, state_d;

  logic             stat_vld;
  logic             stat_rx;
  logic             stat_tx;
  logic [7:0]       thr;
  logic             thr_full;
  logic [7:0]       tmo_cnt;
  logic [7:0]       mem [DEPTH];
  logic [RX_AW-1:0] wp, rp;
  logic [RX_AW:0]   cnt;
  logic             fifo_full;
  logic             busy, done, abort;
  logic             csr_done, push, pop;
  logic [3:0]       err_set;

  assign busy      = state != IDLE;
  assign done      = busy & wbm_ack_i;
  // Bus phase lasts at most TMO cycles with stb high.
  assign abort     = busy & ~wbm_ack_i & (tmo_cnt == TMO_LAST);
  assign csr_done  = done & (state == RD_CSR);
  assign push      = done & (state == RD_RBR);
  assign pop       = rx_vld_o & rx_rdy_i;
  assign fifo_full = cnt[RX_AW];

  assign rx_vld_o  = cnt != '0;
  assign rx_dat_o  = mem[rp];
  assign tx_rdy_o  = ~thr_full;

  always_comb begin
    state_d   = state;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_adr_o = 1'b0;
    wbm_dat_o = 8'h00;
    unique case (state)
      IDLE: begin
        if (en_i) begin
          if (stat_vld & stat_rx & ~fifo_full)
            state_d = RD_RBR;
          else if (stat_vld & stat_tx & thr_full)
            state_d = WR_THR;
          else
            state_d = RD_CSR;
        end
      end
      RD_CSR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_adr_o = 1'b1;
      end
      RD_RBR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
      end
      WR_THR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_dat_o = thr;
      end
      default: state_d = IDLE;
    endcase
    if (done | abort)
      state_d = IDLE;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      tmo_cnt <= 8'h00;
    end else begin
      state <= state_d;
      if (state == IDLE)
        tmo_cnt <= 8'h00;
      else if (~wbm_ack_i)
        tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign err_set = {abort,
                    (csr_done & wbm_dat_i[3]) ? wbm_dat_i[2:0] : 3'b000};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stat_vld <= 1'b0;
      stat_rx  <= 1'b0;
      stat_tx  <= 1'b0;
      thr      <= 8'h00;
      thr_full <= 1'b0;
      err_o    <= 4'h0;
    end else begin
      if (csr_done) begin
        stat_vld <= 1'b1;
        stat_rx  <= wbm_dat_i[3];
        stat_tx  <= wbm_dat_i[7];
      end else if (done | abort) begin
        stat_vld <= 1'b0;
      end
      if (tx_vld_i & ~thr_full) begin
        thr      <= tx_dat_i;
        thr_full <= 1'b1;
      end else if (done & (state == WR_THR)) begin
        thr_full <= 1'b0;
      end
      err_o <= (err_clr_i ? 4'h0 : err_o) | err_set;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      cnt <= cnt + (RX_AW+1)'(push) - (RX_AW+1)'(pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wp] <= wbm_dat_i;
  end

endmodule

// File: tb/tb_uart_wb_host.sv
// Bench for uart_wb_host: UART slave model, bus monitor log and
// RX/TX scoreboards driven from scenario tasks.
module tb_uart_wb_host;
  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_cyc_o;
  logic       wbm_stb_o;
  logic       wbm_we_o;
  logic       wbm_ack_i;
  logic       en_i = 1'b0;
  logic [7:0] tx_dat_i = 8'h00;
  logic       tx_vld_i = 1'b0;
  logic       tx_rdy_o;
  logic [7:0] rx_dat_o;
  logic       rx_vld_o;
  logic       rx_rdy_i = 1'b0;
  logic [3:0] err_o;
  logic       err_clr_i = 1'b0;

  uart_wb_host #(.RX_AW(4), .TMO(255)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_ack_i(wbm_ack_i),
    .en_i     (en_i),
    .tx_dat_i (tx_dat_i),
    .tx_vld_i (tx_vld_i),
    .tx_rdy_o (tx_rdy_o),
    .rx_dat_o (rx_dat_o),
    .rx_vld_o (rx_vld_o),
    .rx_rdy_i (rx_rdy_i),
    .err_o    (err_o),
    .err_clr_i(err_clr_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  localparam int K_CSR = 0;
  localparam int K_RBR = 1;
  localparam int K_THR = 2;

  typedef struct {
    int         kind;
    logic [7:0] dat;
    int         len;
    bit         acked;
    int         gap;
    bit         stable;
  } txn_t;

  int         errors = 0;
  int         checks = 0;
  txn_t       log_q[$];
  int         rd = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  // UART slave model: registered ack, RBR bytes queued in rx_mem
  logic [7:0] csr_base = 8'h00;
  logic [7:0] rx_mem [256];
  int         rx_given = 0;
  int         rx_taken = 0;
  bit         ack_en = 1'b1;
  logic [7:0] csr_eff;

  assign csr_eff = csr_base | ((rx_given != rx_taken) ? 8'h08 : 8'h00);
  assign wbm_dat_i = wbm_adr_o ? csr_eff : rx_mem[rx_taken[7:0]];

  always @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) wbm_ack_i <= 1'b0;
    else wbm_ack_i <= ack_en & wbm_cyc_o & wbm_stb_o & ~wbm_ack_i;

  always @(posedge wb_clk_i)
    if (!wb_rst_i && wbm_ack_i && wbm_stb_o && !wbm_adr_o && !wbm_we_o)
      rx_taken <= rx_taken + 1;

  // Bus monitor, sampled on the falling edge
  int         m_len = 0;
  int         m_gap = 0;
  int         m_gap0 = 0;
  logic       m_adr = 1'b0;
  logic       m_we = 1'b0;
  logic [7:0] m_dat = 8'h00;
  bit         m_stab = 1'b1;
  bit         m_same;
  int         m_gcur;

  function automatic int kind_of(logic adr, logic we);
    return adr ? K_CSR : (we ? K_THR : K_RBR);
  endfunction

  assign m_same = (m_len == 0) || (m_stab && wbm_adr_o == m_adr &&
                  wbm_we_o == m_we && wbm_dat_o == m_dat);
  assign m_gcur = (m_len == 0) ? m_gap : m_gap0;

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      m_len <= 0;
      m_gap <= 0;
    end else if (wbm_cyc_o && wbm_stb_o) begin
      if (m_len == 0) begin
        m_adr  <= wbm_adr_o;
        m_we   <= wbm_we_o;
        m_dat  <= wbm_dat_o;
        m_gap0 <= m_gap;
      end
      m_stab <= m_same;
      if (wbm_ack_i) begin
        log_q.push_back('{kind_of(wbm_adr_o, wbm_we_o), wbm_dat_o,
                          m_len + 1, 1'b1, m_gcur, m_same});
        m_len <= 0;
        m_gap <= 0;
      end else begin
        m_len <= m_len + 1;
      end
    end else begin
      if (m_len != 0) begin
        log_q.push_back('{kind_of(m_adr, m_we), m_dat, m_len,
                          1'b0, m_gap0, m_stab});
        m_len <= 0;
        m_gap <= 1;
      end else begin
        m_gap <= m_gap + 1;
      end
    end
  end

  task automatic get_txn(output txn_t t, output bit ok);
    int n = 0;
    while (log_q.size() <= rd && n < 2000) begin
      @(negedge wb_clk_i); #1;
      n++;
    end
    ok = log_q.size() > rd;
    t = '{0, 8'h00, 0, 1'b0, 0, 1'b0};
    if (ok) begin
      t = log_q[rd];
      rd++;
    end
  endtask

  task automatic sync_log();
    @(negedge wb_clk_i); #1;
    rd = log_q.size();
  endtask

  task automatic give_rx(input logic [7:0] b, input bit track);
    rx_mem[rx_given[7:0]] = b;
    rx_given++;
    if (track) exp_rx.push_back(b);
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got=%b want=0", wbm_cyc_o); end
    checks++; if (wbm_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b want=0", wbm_stb_o); end
    checks++; if (wbm_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", wbm_we_o); end
    checks++; if (wbm_adr_o !== 1'b0) begin errors++; $display("FAIL reset_adr got=%b want=0", wbm_adr_o); end
    checks++; if (wbm_dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat got=%h want=00", wbm_dat_o); end
    checks++; if (rx_vld_o !== 1'b0) begin errors++; $display("FAIL reset_rx_vld got=%b want=0", rx_vld_o); end
    checks++; if (tx_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_tx_rdy got=%b want=1", tx_rdy_o); end
    checks++; if (err_o !== 4'h0) begin errors++; $display("FAIL reset_err got=%h want=0", err_o); end
    wb_rst_i = 1'b0;
  endtask

  task automatic test_poll();
    txn_t t;
    bit ok;
    csr_base = 8'hA0;
    en_i = 1'b1;
    get_txn(t, ok);
    checks++;
    if (!ok || t.kind != K_CSR || !t.acked || t.len != 2) begin
      errors++;
      $display("FAIL first_txn ok=%0d kind=%0d len=%0d want kind=%0d len=2", ok, t.kind, t.len, K_CSR);
    end
    for (int i = 0; i < 4; i++) begin
      get_txn(t, ok);
      checks++;
      if (!ok || t.kind != K_CSR || !t.acked || t.len != 2 || t.gap != 1 || !t.stable) begin
        errors++;
        $display("FAIL poll_txn%0d kind=%0d len=%0d gap=%0d stable=%0d want kind=0 len=2 gap=1 stable=1", i, t.kind, t.len, t.gap, t.stable);
      end
    end
    checks++; if (rx_vld_o !== 1'b0) begin errors++; $display("FAIL poll_rx_vld got=%b want=0", rx_vld_o); end
    checks++; if (tx_rdy_o !== 1'b1) begin errors++; $display("FAIL poll_tx_rdy got=%b want=1", tx_rdy_o); end
  endtask

  task automatic test_rx();
    txn_t t;
    bit ok;
    bit found = 1'b0;
    int n = 0;
    logic [7:0] want;
    csr_base = 8'h20;
    sync_log();
    give_rx(8'h55, 1'b1);
    for (int i = 0; i < 6 && !found; i++) begin
      get_txn(t, ok);
      if (ok && t.kind == K_RBR) found = 1'b1;
    end
    checks++;
    if (!found || !t.acked || t.len != 2 || !t.stable) begin
      errors++;
      $display("FAIL rx_rbr_txn found=%0d len=%0d want found=1 len=2", found, t.len);
    end
    get_txn(t, ok);
    checks++;
    if (!ok || t.kind != K_CSR || t.gap != 1) begin
      errors++;
      $display("FAIL rx_followup kind=%0d gap=%0d want kind=0 gap=1", t.kind, t.gap);
    end
    while (!rx_vld_o && n < 50) begin @(negedge wb_clk_i); n++; end
    want = exp_rx.pop_front();
    checks++;
    if (rx_vld_o !== 1'b1 || rx_dat_o !== want) begin
      errors++;
      $display("FAIL rx_head vld=%b dat=%h want vld=1 dat=%h", rx_vld_o, rx_dat_o, want);
    end
    rx_rdy_i = 1'b1;
    @(negedge wb_clk_i);
    rx_rdy_i = 1'b0;
    checks++; if (rx_vld_o !== 1'b0) begin errors++; $display("FAIL rx_pop_empty got=%b want=0", rx_vld_o); end
  endtask

  task automatic test_tx();
    int n = 0;
    logic [7:0] want;
    csr_base = 8'hA0;
    @(negedge wb_clk_i);
    tx_dat_i = 8'h3C;
    tx_vld_i = 1'b1;
    exp_tx.push_back(8'h3C);
    @(posedge wb_clk_i); #1;
    tx_vld_i = 1'b0;
    checks++; if (tx_rdy_o !== 1'b0) begin errors++; $display("FAIL tx_rdy_busy got=%b want=0", tx_rdy_o); end
    @(negedge wb_clk_i);
    while (!(wbm_stb_o && wbm_we_o && wbm_ack_i) && n < 50) begin @(negedge wb_clk_i); n++; end
    want = exp_tx.pop_front();
    checks++;
    if (!(wbm_stb_o && wbm_we_o && wbm_ack_i) || wbm_dat_o !== want || wbm_adr_o !== 1'b0) begin
      errors++;
      $display("FAIL tx_write stb=%b we=%b adr=%b dat=%h want we=1 adr=0 dat=%h", wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, want);
    end
    @(negedge wb_clk_i);
    checks++; if (tx_rdy_o !== 1'b1) begin errors++; $display("FAIL tx_rdy_after got=%b want=1", tx_rdy_o); end
    checks++; if (err_o !== 4'h0) begin errors++; $display("FAIL tx_err got=%h want=0", err_o); end
  endtask

  task automatic test_fifo_full();
    int rbr;
    int n;
    logic [7:0] want;
    csr_base = 8'h20;
    rx_rdy_i = 1'b0;
    sync_log();
    for (int i = 0; i < 18; i++) give_rx(8'(8'hF0 + i), 1'b1);
    repeat (200) @(negedge wb_clk_i);
    #1;
    rbr = 0;
    for (int i = rd; i < log_q.size(); i++) if (log_q[i].kind == K_RBR) rbr++;
    checks++; if (rbr != 16) begin errors++; $display("FAIL fifo_fill_count got=%0d want=16", rbr); end
    checks++; if (rx_vld_o !== 1'b1) begin errors++; $display("FAIL fifo_full_vld got=%b want=1", rx_vld_o); end
    rd = log_q.size();
    want = exp_rx.pop_front();
    checks++; if (rx_dat_o !== want) begin errors++; $display("FAIL fifo_pop0 got=%h want=%h", rx_dat_o, want); end
    rx_rdy_i = 1'b1;
    @(negedge wb_clk_i);
    rx_rdy_i = 1'b0;
    repeat (60) @(negedge wb_clk_i);
    #1;
    rbr = 0;
    for (int i = rd; i < log_q.size(); i++) if (log_q[i].kind == K_RBR) rbr++;
    checks++; if (rbr != 1) begin errors++; $display("FAIL fifo_refill_count got=%0d want=1", rbr); end
    for (int i = 0; i < 17; i++) begin
      n = 0;
      while (!rx_vld_o && n < 50) begin @(negedge wb_clk_i); n++; end
      want = exp_rx.pop_front();
      checks++;
      if (rx_vld_o !== 1'b1 || rx_dat_o !== want) begin
        errors++;
        $display("FAIL fifo_order%0d vld=%b got=%h want=%h", i, rx_vld_o, rx_dat_o, want);
      end
      rx_rdy_i = 1'b1;
      @(negedge wb_clk_i);
      rx_rdy_i = 1'b0;
    end
    repeat (20) @(negedge wb_clk_i);
    checks++; if (rx_vld_o !== 1'b0) begin errors++; $display("FAIL fifo_drained got=%b want=0", rx_vld_o); end
  endtask

  task automatic test_timeout();
    txn_t t;
    bit ok;
    bit found = 1'b0;
    int n = 0;
    logic [7:0] want;
    csr_base = 8'h20;
    sync_log();
    ack_en = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      get_txn(t, ok);
      if (ok && !t.acked) found = 1'b1;
    end
    checks++;
    if (!found || t.len != 255 || t.kind != K_CSR) begin
      errors++;
      $display("FAIL tmo_abort found=%0d len=%0d kind=%0d want len=255 kind=0", found, t.len, t.kind);
    end
    checks++; if (err_o !== 4'h8) begin errors++; $display("FAIL tmo_err got=%h want=8", err_o); end
    ack_en = 1'b1;
    get_txn(t, ok);
    checks++;
    if (!ok || t.kind != K_CSR || !t.acked || t.gap != 1) begin
      errors++;
      $display("FAIL tmo_retry kind=%0d acked=%0d gap=%0d want kind=0 acked=1 gap=1", t.kind, t.acked, t.gap);
    end
    err_clr_i = 1'b1;
    @(negedge wb_clk_i);
    err_clr_i = 1'b0;
    checks++; if (err_o !== 4'h0) begin errors++; $display("FAIL tmo_clr got=%h want=0", err_o); end
    csr_base = 8'h25;
    give_rx(8'h99, 1'b1);
    while (!rx_vld_o && n < 50) begin @(negedge wb_clk_i); n++; end
    checks++; if (err_o !== 4'h5) begin errors++; $display("FAIL err_flags got=%h want=5", err_o); end
    want = exp_rx.pop_front();
    checks++; if (rx_dat_o !== want) begin errors++; $display("FAIL err_byte got=%h want=%h", rx_dat_o, want); end
    rx_rdy_i = 1'b1;
    @(negedge wb_clk_i);
    rx_rdy_i = 1'b0;
    csr_base = 8'h20;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    csr_base = 8'hA0;
    give_rx(8'h77, 1'b0);
    while (!rx_vld_o && n < 50) begin @(negedge wb_clk_i); n++; end
    tx_dat_i = 8'h5A;
    tx_vld_i = 1'b1;
    @(negedge wb_clk_i);
    tx_vld_i = 1'b0;
    n = 0;
    while (!(wbm_stb_o && wbm_we_o) && n < 50) begin @(negedge wb_clk_i); n++; end
    checks++;
    if (!(wbm_stb_o && wbm_we_o) || rx_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup stb=%b we=%b rx_vld=%b want 1 1 1", wbm_stb_o, wbm_we_o, rx_vld_o);
    end
    #2 wb_rst_i = 1'b1;
    #1;
    checks++; if (wbm_stb_o !== 1'b0) begin errors++; $display("FAIL mid_stb got=%b want=0", wbm_stb_o); end
    checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL mid_cyc got=%b want=0", wbm_cyc_o); end
    checks++; if (wbm_we_o !== 1'b0) begin errors++; $display("FAIL mid_we got=%b want=0", wbm_we_o); end
    checks++; if (wbm_dat_o !== 8'h00) begin errors++; $display("FAIL mid_dat got=%h want=00", wbm_dat_o); end
    checks++; if (tx_rdy_o !== 1'b1) begin errors++; $display("FAIL mid_tx_rdy got=%b want=1", tx_rdy_o); end
    checks++; if (rx_vld_o !== 1'b0) begin errors++; $display("FAIL mid_rx_vld got=%b want=0", rx_vld_o); end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_poll();
    test_rx();
    test_tx();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
